// File: rtl/pipe_mem_arbiter.sv
// pipe_mem_arbiter: one single-port memory shared by fetch and data ports.
// Define INST_BUF_EN to add a one-entry fetch buffer in front of memory.
module pipe_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_adr,
  output logic [DATA_W-1:0] inst,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_adr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    RESP
  } state_t;

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  state_t            state_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_adr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] inst_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              if_ready_q;
  logic              d_ready_q;
  logic [3:0]        starve_q;
  logic [3:0]        starve_d;

  logic              hit;
  logic [DATA_W-1:0] hit_data;
  logic              fetch_win;
  logic              data_win;

`ifdef INST_BUF_EN
  logic              buf_valid_q;
  logic [ADDR_W-1:0] buf_adr_q;
  logic [DATA_W-1:0] buf_data_q;

  assign hit      = if_req && buf_valid_q
                 && (buf_adr_q == if_adr);
  assign hit_data = buf_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid_q <= 1'b0;
      buf_adr_q   <= '0;
      buf_data_q  <= '0;
    end else if (state_q == BUSY_I && mem_ready) begin
      buf_valid_q <= 1'b1;
      buf_adr_q   <= mem_adr_q;
      buf_data_q  <= mem_rdata;
    end else if (state_q == IDLE && data_win
                 && d_we && d_adr == buf_adr_q) begin
      buf_valid_q <= 1'b0;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  // A buffered fetch never contends, so data wins alongside it.
  assign fetch_win = if_req && !hit
                  && (!d_req || starve_q == SMAX);
  assign data_win  = d_req && !fetch_win;

  assign starve_d = (starve_q >= SMAX) ? SMAX
                  : starve_q + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_adr_q   <= '0;
      mem_wdata_q <= '0;
      inst_q      <= '0;
      d_rdata_q   <= '0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
      starve_q    <= 4'd0;
    end else begin
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (data_win) begin
            state_q     <= BUSY_D;
            mem_req_q   <= 1'b1;
            mem_we_q    <= d_we;
            mem_adr_q   <= d_adr;
            mem_wdata_q <= d_wdata;
            if (if_req) starve_q <= starve_d;
          end else if (fetch_win) begin
            state_q   <= BUSY_I;
            mem_req_q <= 1'b1;
            mem_we_q  <= 1'b0;
            mem_adr_q <= if_adr;
            starve_q  <= 4'd0;
          end else if (hit) begin
            state_q <= RESP;
          end
          if (hit) begin
            inst_q     <= hit_data;
            if_ready_q <= 1'b1;
            starve_q   <= 4'd0;
          end
        end
        BUSY_I: begin
          if (mem_ready) begin
            state_q    <= RESP;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            inst_q     <= mem_rdata;
            if_ready_q <= 1'b1;
          end
        end
        BUSY_D: begin
          if (mem_ready) begin
            state_q   <= RESP;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            d_ready_q <= 1'b1;
            if (!mem_we_q) d_rdata_q <= mem_rdata;
          end
        end
        RESP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_adr   = mem_adr_q;
  assign mem_wdata = mem_wdata_q;
  assign inst      = inst_q;
  assign d_rdata   = d_rdata_q;
  assign if_ready  = if_ready_q;
  assign d_ready   = d_ready_q;

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// tb_pipe_mem_arbiter: directed and random traffic against a
// transaction-timing reference model of the shared-memory arbiter.
module tb_pipe_mem_arbiter;
  localparam int SMAX = 4;
`ifdef INST_BUF_EN
  localparam bit BUF = 1'b1;
`else
  localparam bit BUF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic if_req, if_ready, d_req, d_we, d_ready;
  logic [31:0] if_adr, inst, d_adr, d_wdata, d_rdata;
  logic mem_req, mem_we, mem_ready;
  logic [31:0] mem_adr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  pipe_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_adr(if_adr),
    .inst(inst), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_adr(d_adr),
    .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_ready(d_ready),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_adr(mem_adr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  // Memory model with programmable wait states.
  logic [31:0] mem_arr [32];
  bit written [32];
  int wcnt;
  int cur_w;
  logic stray;

  function automatic logic [31:0] init_val(int i);
    if (i == 4) return 32'h8C020004;
    return 32'hA5000000 ^ (32'(i) * 32'h00012345);
  endfunction

  always_ff @(posedge clk) begin
    if (mem_req && !mem_ready) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (mem_req && mem_ready && mem_we) begin
      mem_arr[mem_adr[6:2]] <= mem_wdata;
      written[mem_adr[6:2]] <= 1'b1;
    end
  end

  assign mem_ready = mem_req ? (wcnt >= cur_w) : stray;
  assign mem_rdata = written[mem_adr[6:2]]
                   ? mem_arr[mem_adr[6:2]]
                   : init_val(int'(mem_adr[6:2]));

  int vectors = 0;
  int errors = 0;

  // Reference model state
  int n, nd;
  bit fl_act;
  int fl_s, fl_e;
  logic fl_we;
  logic [31:0] fl_adr, fl_wd;
  int ir_cyc, dr_cyc;
  logic [31:0] ir_data, dr_data;
  bit dr_upd;
  logic [31:0] e_inst, e_drd;
  bit e_ir, e_dr, inflt;
  int sc;
  bit bv;
  logic [31:0] ba, bd;
  logic [31:0] ref_mem [32];

  // Requesters
  bit f_pend, f_ret, d_pend, d_ret;
  logic [31:0] f_a, d_a, d_w;
  logic d_wr;
  int f_left, d_left, p_f, p_d, d_mode, force_w;
  bit f_fix_en, d_fix_en;
  logic [31:0] f_fix, d_fix_a, d_fix_w;
  bit rst_req, stray_rand, stray_force;

  // Observations
  int ir_seen, dr_seen, last_ir, last_dr;
  int dr0, dr_at_ir, n0, b;
  bit ir_flag;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    fl_act = 0; ir_cyc = -1; dr_cyc = -1;
    e_inst = '0; e_drd = '0; sc = 0;
    bv = 0; ba = '0; bd = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    n++;
    e_ir = (n == ir_cyc);
    e_dr = (n == dr_cyc);
    if (e_ir) e_inst = ir_data;
    if (e_dr && dr_upd) e_drd = dr_data;
    inflt = fl_act && n >= fl_s && n <= fl_e;
    if (fl_act && n > fl_e) fl_act = 0;
    chk("if_ready", {31'd0, if_ready}, {31'd0, e_ir});
    chk("d_ready", {31'd0, d_ready}, {31'd0, e_dr});
    chk("inst", inst, e_inst);
    chk("d_rdata", d_rdata, e_drd);
    chk("mem_req", {31'd0, mem_req}, {31'd0, inflt});
    chk("mem_we", {31'd0, mem_we},
        {31'd0, inflt && fl_we});
    if (inflt) chk("mem_adr", mem_adr, fl_adr);
    if (inflt && fl_we)
      chk("mem_wdata", mem_wdata, fl_wd);
    if (if_ready) begin
      ir_seen++; last_ir = n;
      if (!ir_flag) begin
        ir_flag = 1; dr_at_ir = dr_seen - dr0;
      end
    end
    if (d_ready) begin dr_seen++; last_dr = n; end
    if (f_ret) begin f_pend = 0; f_ret = 0; end
    if (e_ir) f_ret = 1;
    if (d_ret) begin d_pend = 0; d_ret = 0; end
    if (e_dr) d_ret = 1;
  endtask

  task automatic decide();
    bit hit, fc;
    int w;
    hit = BUF && f_pend && bv && (ba == f_a);
    fc = f_pend && !hit;
    w = (force_w >= 0) ? force_w : int'($urandom_range(0, 2));
    if (hit) begin ir_cyc = n + 1; ir_data = bd; end
    if (d_pend && (!fc || sc != SMAX)) begin
      cur_w = w; fl_act = 1;
      fl_s = n + 1; fl_e = n + 1 + w;
      fl_we = d_wr; fl_adr = d_a; fl_wd = d_w;
      dr_cyc = n + 2 + w; dr_upd = !d_wr;
      dr_data = ref_mem[d_a[6:2]];
      if (d_wr) begin
        ref_mem[d_a[6:2]] = d_w;
        if (d_a == ba) bv = 0;
      end
      if (fc) sc = (sc < SMAX) ? sc + 1 : SMAX;
      nd = n + 3 + w;
    end else if (fc) begin
      cur_w = w; fl_act = 1;
      fl_s = n + 1; fl_e = n + 1 + w;
      fl_we = 0; fl_adr = f_a;
      ir_cyc = n + 2 + w;
      ir_data = ref_mem[f_a[6:2]];
      sc = 0; nd = n + 3 + w;
      if (BUF) begin bv = 1; ba = f_a; bd = ir_data; end
    end else if (hit) begin
      nd = n + 2;
    end else begin
      nd = n + 1;
    end
    if (hit) sc = 0;
  endtask

  task automatic go();
    rst = 0;
    stray = stray_force
         | (stray_rand & ($urandom_range(0, 1) == 1));
    if (rst_req) begin
      rst_req = 0; rst = 1;
      model_clear();
      f_pend = 0; d_pend = 0; f_ret = 0; d_ret = 0;
      nd = n + 1;
    end else begin
      if (!f_pend && f_left > 0
          && $urandom_range(0, 99) < p_f) begin
        f_pend = 1; f_left--;
        f_a = f_fix_en ? f_fix
            : 32'($urandom_range(0, 7)) << 2;
      end
      if (!d_pend && d_left > 0
          && $urandom_range(0, 99) < p_d) begin
        d_pend = 1; d_left--;
        d_wr = (d_mode == 2) ? ($urandom_range(0, 1) == 1)
             : (d_mode == 1);
        d_a = d_fix_en ? d_fix_a
            : 32'($urandom_range(0, 15)) << 2;
        d_w = d_fix_en ? d_fix_w : $urandom;
      end
      if (n == nd) decide();
    end
    if_req = f_pend; if_adr = f_a;
    d_req = d_pend; d_we = d_wr;
    d_adr = d_a; d_wdata = d_w;
  endtask

  task automatic cyc();
    tick();
    go();
  endtask

  task automatic drain();
    b = 0;
    while ((f_pend || d_pend || f_left > 0 || d_left > 0
            || nd > n + 1) && b < 80) begin
      cyc(); b++;
    end
    chk("drain_timeout", 32'(b >= 80), 32'd0);
  endtask

  task automatic seg_start();
    n0 = n + 1; ir_flag = 0; dr0 = dr_seen;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);
    rst = 1; if_req = 0; d_req = 0; d_we = 0;
    if_adr = '0; d_adr = '0; d_wdata = '0;
    stray = 0; cur_w = 0;
    f_pend = 0; d_pend = 0; f_ret = 0; d_ret = 0;
    f_a = '0; d_a = '0; d_w = '0; d_wr = 0;
    f_left = 0; d_left = 0; p_f = 100; p_d = 100;
    d_mode = 0; force_w = 0; f_fix_en = 1; d_fix_en = 1;
    f_fix = '0; d_fix_a = '0; d_fix_w = '0;
    rst_req = 0; stray_rand = 0; stray_force = 0;
    ir_seen = 0; dr_seen = 0; last_ir = -1; last_dr = -1;
    ir_flag = 0; dr0 = 0; dr_at_ir = -1;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_adr", mem_adr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_if_ready", {31'd0, if_ready}, 32'd0);
    chk("rst_d_ready", {31'd0, d_ready}, 32'd0);
    rst = 0; n = 0; nd = 1;

    // Lone fetch, zero waits
    seg_start();
    f_fix = 32'h10; f_left = 1; force_w = 0;
    drain();
    chk("lone_fetch_cycle", 32'(last_ir - n0), 32'd2);

    // Simultaneous fetch and data read
    seg_start();
    f_fix = 32'h08; f_left = 1;
    d_fix_a = 32'h40; d_mode = 0; d_left = 1;
    drain();
    chk("contest_d_cycle", 32'(last_dr - n0), 32'd2);
    chk("contest_i_cycle", 32'(last_ir - n0), 32'd5);

    // Starvation guard
    seg_start();
    f_fix = 32'h0C; f_left = 1; d_left = 5;
    drain();
    chk("starve_d_before_i", 32'(dr_at_ir), 32'(SMAX));

    // Write with two wait states
    seg_start();
    d_fix_a = 32'h20; d_fix_w = 32'hDEADBEEF;
    d_mode = 1; force_w = 2; d_left = 1;
    drain();
    chk("write_d_cycle", 32'(last_dr - n0), 32'd4);

`ifdef INST_BUF_EN
    seg_start();
    f_fix = 32'h10; f_left = 2; force_w = 0;
    drain();
    chk("buf_hit_cycle", 32'(last_ir - n0), 32'd4);
    seg_start();
    d_fix_a = 32'h10; d_fix_w = 32'h13579BDF;
    d_mode = 1; d_left = 1;
    drain();
    seg_start();
    f_left = 1;
    drain();
    chk("buf_inval_cycle", 32'(last_ir - n0), 32'd2);
    chk("buf_inval_inst", inst, 32'h13579BDF);
`endif

    // Random traffic
    f_fix_en = 0; d_fix_en = 0; d_mode = 2;
    force_w = -1; stray_rand = 1;
    p_f = 35; p_d = 35; f_left = 10000; d_left = 10000;
    repeat (600) cyc();
    f_left = 0; d_left = 0;
    drain();

    // Reset in the middle of a data access
    stray_rand = 0; p_f = 100; p_d = 100;
    d_fix_en = 1; d_fix_a = 32'h40; d_mode = 0;
    force_w = 20; d_left = 1;
    cyc(); cyc();
    chk("busy_mem_req", {31'd0, mem_req}, 32'd1);
    rst_req = 1;
    cyc(); cyc();
    chk("mid_mem_req", {31'd0, mem_req}, 32'd0);
    chk("mid_mem_we", {31'd0, mem_we}, 32'd0);
    chk("mid_mem_adr", mem_adr, 32'd0);
    chk("mid_mem_wdata", mem_wdata, 32'd0);
    chk("mid_inst", inst, 32'd0);
    chk("mid_d_rdata", d_rdata, 32'd0);
    chk("mid_if_ready", {31'd0, if_ready}, 32'd0);
    chk("mid_d_ready", {31'd0, d_ready}, 32'd0);
    dr0 = dr_seen;
    stray_force = 1;
    repeat (4) cyc();
    stray_force = 0;
    chk("stray_ready_pulses", 32'(dr_seen - dr0), 32'd0);

    // More random traffic after reset
    d_fix_en = 0; d_mode = 2; force_w = -1;
    stray_rand = 1; p_f = 40; p_d = 40;
    f_left = 10000; d_left = 10000;
    repeat (300) cyc();
    f_left = 0; d_left = 0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end
endmodule
